// File: rtl/cpu_clock_sequencer.sv
// Purpose: issues the 6502 clock-enable from 1 Hz tick, fast divider or every CLK, with halt/step/break.
// Latency: CPU_CE is registered, 1 CLK after the qualifying source or step event.
// Backpressure: none; RUN_REQ/BREAK gate issue. Optional CYCLE_COUNTER_EN macro enables CYCLE_COUNT.
module cpu_clock_sequencer #(
    parameter int FAST_DIV        = 50,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        TICK_1HZ,
    input  logic [1:0]  MODE,
    input  logic        RUN_REQ,
    input  logic        STEP_BTN,
    input  logic        BREAK,
    output logic        CPU_CE,
    output logic        RUNNING,
    output logic        HALTED_BY_BREAK,
    output logic [31:0] CYCLE_COUNT
);

    localparam int DIV_W = (FAST_DIV > 2) ? $clog2(FAST_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        BRK  = 2'd2
    } state_t;

    state_t                   state;
    logic [DIV_W-1:0]         div;
    logic                     div_tc;
    logic                     src;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     synced;
    logic [DB_W-1:0]          db_cnt;
    logic                     deb_level;
    logic                     deb_prev;
    logic                     step_evt;

    assign div_tc   = (div == DIV_W'(FAST_DIV - 1));
    assign synced   = sync_q[SYNC_STAGES-1];
    assign step_evt = deb_level & ~deb_prev;

    always_comb begin
        src = 1'b0;
        case (MODE)
            2'b00:   src = TICK_1HZ;
            2'b01:   src = div_tc;
            2'b10:   src = 1'b1;
            default: src = 1'b0;
        endcase
    end

    // Divider only runs while actually running in fast mode, so any mode change restarts it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div <= '0;
        end else if (state == RUN && MODE == 2'b01) begin
            div <= div_tc ? '0 : div + 1'b1;
        end else begin
            div <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], STEP_BTN};
        end
    end

    // Counts consecutive samples that disagree with the current level; any agreeing sample restarts.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            db_cnt    <= '0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            if (synced == deb_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt    <= '0;
                deb_level <= synced;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= HALT;
            CPU_CE          <= 1'b0;
            RUNNING         <= 1'b0;
            HALTED_BY_BREAK <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    CPU_CE <= step_evt;
                    if (RUN_REQ) begin
                        state           <= RUN;
                        RUNNING         <= 1'b1;
                        HALTED_BY_BREAK <= 1'b0;
                    end
                end
                RUN: begin
                    CPU_CE <= src;
                    if (!RUN_REQ) begin
                        state           <= HALT;
                        RUNNING         <= 1'b0;
                        HALTED_BY_BREAK <= 1'b0;
                    end else if (src && BREAK) begin
                        state           <= BRK;
                        RUNNING         <= 1'b0;
                        HALTED_BY_BREAK <= 1'b1;
                    end
                end
                BRK: begin
                    CPU_CE <= step_evt;
                    if (!RUN_REQ) begin
                        state           <= HALT;
                        RUNNING         <= 1'b0;
                        HALTED_BY_BREAK <= 1'b0;
                    end
                end
                default: begin
                    state           <= HALT;
                    CPU_CE          <= 1'b0;
                    RUNNING         <= 1'b0;
                    HALTED_BY_BREAK <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_cnt <= '0;
        end else if (CPU_CE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign CYCLE_COUNT = cycle_cnt;
`else
    assign CYCLE_COUNT = 32'h0;
`endif

endmodule
